// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin arbiter that shares one fixed-latency RAM port
// among COUNT requesters and slots in periodic refresh cycles between accesses.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   REQ/REQ_WE/REQ_SIZE per-requester request level, write flag, write size
//   REQ_ADDR/REQ_DIN    packed per-requester address and write data
//   ACK                 one-cycle one-hot grant pulse (command cycle)
//   VALID/DOUT          one-cycle one-hot read-valid pulse and broadcast read data
//   RAM_ADDR/RAM_DIN/RAM_DIN_SIZE  RAM command payload, held through the access
//   RAM_OE_n/RAM_WE_n/RAM_RFSH_n   one-cycle active-low RAM strobes
//   RAM_DOUT            RAM read data
//   RFSH_MISSED         sticky flag: a refresh interval expired with one still pending
module ram_access_arbiter #(
    parameter int unsigned COUNT            = 5,
    parameter int unsigned ADDR_W           = 22,
    parameter int unsigned ACCESS_CYCLES    = 4,
    parameter int unsigned REFRESH_INTERVAL = 256
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [COUNT-1:0]        REQ,
    input  logic [COUNT-1:0]        REQ_WE,
    input  logic [COUNT*ADDR_W-1:0] REQ_ADDR,
    input  logic [COUNT*16-1:0]     REQ_DIN,
    input  logic [COUNT-1:0]        REQ_SIZE,
    output logic [COUNT-1:0]        ACK,
    output logic [COUNT-1:0]        VALID,
    output logic [15:0]             DOUT,
    output logic [ADDR_W-1:0]       RAM_ADDR,
    output logic [15:0]             RAM_DIN,
    output logic                    RAM_DIN_SIZE,
    output logic                    RAM_OE_n,
    output logic                    RAM_WE_n,
    output logic                    RAM_RFSH_n,
    input  logic [15:0]             RAM_DOUT,
    output logic                    RFSH_MISSED
);

    localparam int unsigned IDX_W  = $clog2(COUNT);
    localparam int unsigned WCNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam int unsigned RCNT_W = $clog2(REFRESH_INTERVAL + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(COUNT - 1);
    localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(ACCESS_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(REFRESH_INTERVAL - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_RFSH = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic [RCNT_W-1:0] rcnt;
    logic              rfsh_pending;
    logic [IDX_W-1:0]  last_grant;
    logic              lat_read;

    logic [COUNT-1:0]  ack_nxt, valid_nxt;
    logic              oe_n_nxt, we_n_nxt, rfsh_n_nxt;
    logic              grant, start_rfsh, rfsh_clear, capture;

    logic              found;
    logic [IDX_W-1:0]  winner;
    int unsigned       cand;

    logic [ADDR_W-1:0] addr_arr [COUNT];
    logic [15:0]       din_arr  [COUNT];

    // Unpack the per-requester address and data buses
    for (genvar i = 0; i < COUNT; i++) begin : g_unpack
        assign addr_arr[i] = REQ_ADDR[i*ADDR_W +: ADDR_W];
        assign din_arr[i]  = REQ_DIN[i*16 +: 16];
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int unsigned k = 1; k <= COUNT; k++) begin
            cand = (32'(last_grant) + k) % COUNT;
            if (!found && REQ[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        ack_nxt    = '0;
        valid_nxt  = '0;
        oe_n_nxt   = 1'b1;
        we_n_nxt   = 1'b1;
        rfsh_n_nxt = 1'b1;
        grant      = 1'b0;
        start_rfsh = 1'b0;
        rfsh_clear = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                // Pending refresh beats any request arriving in the same cycle
                if (rfsh_pending) begin
                    state_nxt  = S_RFSH;
                    rfsh_n_nxt = 1'b0;
                    start_rfsh = 1'b1;
                end else if (found) begin
                    state_nxt       = S_CMD;
                    grant           = 1'b1;
                    ack_nxt[winner] = 1'b1;
                    if (REQ_WE[winner]) we_n_nxt = 1'b0;
                    else                oe_n_nxt = 1'b0;
                end
            end
            S_CMD: begin
                state_nxt = S_WAIT;
                wcnt_nxt  = WAIT_LOAD;
            end
            S_RFSH: begin
                state_nxt  = S_WAIT;
                wcnt_nxt   = WAIT_LOAD;
                rfsh_clear = 1'b1;
            end
            S_WAIT: begin
                if (wcnt == '0) begin
                    state_nxt = S_IDLE;
                    if (lat_read) begin
                        valid_nxt[last_grant] = 1'b1;
                        capture               = 1'b1;
                    end
                end else begin
                    wcnt_nxt = wcnt - WCNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and strobe/handshake registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            ACK        <= '0;
            VALID      <= '0;
            RAM_OE_n   <= 1'b1;
            RAM_WE_n   <= 1'b1;
            RAM_RFSH_n <= 1'b1;
        end else begin
            state      <= state_nxt;
            wcnt       <= wcnt_nxt;
            ACK        <= ack_nxt;
            VALID      <= valid_nxt;
            RAM_OE_n   <= oe_n_nxt;
            RAM_WE_n   <= we_n_nxt;
            RAM_RFSH_n <= rfsh_n_nxt;
        end
    end

    // Command latch and read data; the RAM payload registers are the latch
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_grant   <= LAST_IDX;
            lat_read     <= 1'b0;
            RAM_ADDR     <= '0;
            RAM_DIN      <= '0;
            RAM_DIN_SIZE <= 1'b0;
            DOUT         <= '0;
        end else begin
            if (grant) begin
                last_grant   <= winner;
                lat_read     <= ~REQ_WE[winner];
                RAM_ADDR     <= addr_arr[winner];
                RAM_DIN      <= din_arr[winner];
                RAM_DIN_SIZE <= REQ_SIZE[winner];
            end else if (start_rfsh) begin
                lat_read <= 1'b0;
            end
            if (capture) DOUT <= RAM_DOUT;
        end
    end

    // Free-running refresh timer; a second expiry with one still queued is flagged
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rcnt         <= RCNT_LOAD;
            rfsh_pending <= 1'b0;
            RFSH_MISSED  <= 1'b0;
        end else if (rcnt == '0) begin
            rcnt         <= RCNT_LOAD;
            rfsh_pending <= 1'b1;
            if (rfsh_pending && !rfsh_clear) RFSH_MISSED <= 1'b1;
        end else begin
            rcnt <= rcnt - RCNT_W'(1);
            if (rfsh_clear) rfsh_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
module tb_ram_access_arbiter;

    localparam int unsigned N  = 5;
    localparam int unsigned AW = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Shared stimulus
    logic          rst, rst_bc;
    logic [N-1:0]  req, req_we, req_size, req_b, req_c;
    logic [N*AW-1:0] req_addr;
    logic [N*16-1:0] req_din;
    logic [15:0]   ram_dout;

    // DUT A: functional tests (refresh every 64 cycles)
    logic [N-1:0]  ack, valid;
    logic [15:0]   dout, ram_din;
    logic [AW-1:0] ram_addr;
    logic          ram_din_size, oe_n, we_n, rfsh_n, missed;

    // DUT B: refresh every 8 cycles under continuous requests
    logic [N-1:0]  b_ack, b_valid;
    logic [15:0]   b_dout, b_ram_din;
    logic [AW-1:0] b_ram_addr;
    logic          b_size, b_oe_n, b_we_n, b_rfsh_n, b_missed;

    // DUT C: interval shorter than an access, so refreshes pile up
    logic [N-1:0]  c_ack, c_valid;
    logic [15:0]   c_dout, c_ram_din;
    logic [AW-1:0] c_ram_addr;
    logic          c_size, c_oe_n, c_we_n, c_rfsh_n, c_missed;

    ram_access_arbiter #(.COUNT(N), .ADDR_W(AW), .ACCESS_CYCLES(4), .REFRESH_INTERVAL(64)) dut (
        .CLK(clk), .RESET(rst), .REQ(req), .REQ_WE(req_we), .REQ_ADDR(req_addr),
        .REQ_DIN(req_din), .REQ_SIZE(req_size), .ACK(ack), .VALID(valid), .DOUT(dout),
        .RAM_ADDR(ram_addr), .RAM_DIN(ram_din), .RAM_DIN_SIZE(ram_din_size),
        .RAM_OE_n(oe_n), .RAM_WE_n(we_n), .RAM_RFSH_n(rfsh_n), .RAM_DOUT(ram_dout),
        .RFSH_MISSED(missed));

    ram_access_arbiter #(.COUNT(N), .ADDR_W(AW), .ACCESS_CYCLES(4), .REFRESH_INTERVAL(8)) dut_b (
        .CLK(clk), .RESET(rst_bc), .REQ(req_b), .REQ_WE(req_we), .REQ_ADDR(req_addr),
        .REQ_DIN(req_din), .REQ_SIZE(req_size), .ACK(b_ack), .VALID(b_valid), .DOUT(b_dout),
        .RAM_ADDR(b_ram_addr), .RAM_DIN(b_ram_din), .RAM_DIN_SIZE(b_size),
        .RAM_OE_n(b_oe_n), .RAM_WE_n(b_we_n), .RAM_RFSH_n(b_rfsh_n), .RAM_DOUT(ram_dout),
        .RFSH_MISSED(b_missed));

    ram_access_arbiter #(.COUNT(N), .ADDR_W(AW), .ACCESS_CYCLES(4), .REFRESH_INTERVAL(3)) dut_c (
        .CLK(clk), .RESET(rst_bc), .REQ(req_c), .REQ_WE(req_we), .REQ_ADDR(req_addr),
        .REQ_DIN(req_din), .REQ_SIZE(req_size), .ACK(c_ack), .VALID(c_valid), .DOUT(c_dout),
        .RAM_ADDR(c_ram_addr), .RAM_DIN(c_ram_din), .RAM_DIN_SIZE(c_size),
        .RAM_OE_n(c_oe_n), .RAM_WE_n(c_we_n), .RAM_RFSH_n(c_rfsh_n), .RAM_DOUT(ram_dout),
        .RFSH_MISSED(c_missed));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int rcount;
    logic [N-1:0] exp_ack, exp_valid;

    initial begin
        rst = 1'b1; rst_bc = 1'b1;
        req = '0; req_we = '0; req_size = '1; req_addr = '0; req_din = '0;
        req_b = '1; req_c = '0; ram_dout = 16'hDEAD;
        rcount = 0;
        tick(); tick();

        // Refresh cadence with continuous requests, and overflow detection
        rst_bc = 1'b0;
        for (int k = 1; k <= 207; k++) begin
            tick();
            if (!b_rfsh_n) rcount++;
            chk("b_strobe_excl", 32'(({1'b0, ~b_oe_n} + {1'b0, ~b_we_n} + {1'b0, ~b_rfsh_n}) > 2'd1), 32'd0);
            chk("b_missed_low", 32'(b_missed), 32'd0);
            if (k == 8) chk("c_missed_before", 32'(c_missed), 32'd0);
            if (k == 9) chk("c_missed_after", 32'(c_missed), 32'd1);
        end
        chk("b_rfsh_count", 32'(rcount), 32'd25);
        rst_bc = 1'b1;

        // Reset values
        tick();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_din", 32'(ram_din), 32'd0);
        chk("rst_size", 32'(ram_din_size), 32'd0);
        chk("rst_oe", 32'(oe_n), 32'd1);
        chk("rst_we", 32'(we_n), 32'd1);
        chk("rst_rfsh", 32'(rfsh_n), 32'd1);
        chk("rst_missed", 32'(missed), 32'd0);

        // Single read from requester 2
        rst = 1'b0;
        req = 5'b00100;
        req_addr[2*AW +: AW] = 22'h001234;
        tick();
        chk("rd_ack", 32'(ack), 32'h04);
        chk("rd_oe", 32'(oe_n), 32'd0);
        chk("rd_we", 32'(we_n), 32'd1);
        chk("rd_addr", 32'(ram_addr), 32'h001234);
        tick();
        req = '0;
        chk("rd_ack_end", 32'(ack), 32'd0);
        chk("rd_oe_end", 32'(oe_n), 32'd1);
        chk("rd_addr_hold", 32'(ram_addr), 32'h001234);
        tick(); tick(); tick();
        ram_dout = 16'hBEEF;
        chk("rd_valid_early", 32'(valid), 32'd0);
        tick();
        ram_dout = 16'h1111;
        chk("rd_valid", 32'(valid), 32'h04);
        chk("rd_dout", 32'(dout), 32'hBEEF);
        tick();
        chk("rd_valid_end", 32'(valid), 32'd0);
        chk("rd_dout_hold", 32'(dout), 32'hBEEF);

        // Reset in the middle of a read's wait phase
        req = 5'b01000;
        req_addr[3*AW +: AW] = 22'h2ABCDE;
        tick();
        chk("mr_ack", 32'(ack), 32'h08);
        chk("mr_addr", 32'(ram_addr), 32'h2ABCDE);
        tick();
        req = '0;
        tick();
        rst = 1'b1;
        #1;
        chk("mr_async_oe", 32'(oe_n), 32'd1);
        chk("mr_async_addr", 32'(ram_addr), 32'd0);
        chk("mr_async_dout", 32'(dout), 32'd0);
        tick(); tick();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("mr_no_valid", 32'(valid), 32'd0);
            chk("mr_no_ack", 32'(ack), 32'd0);
        end
        req = 5'b11001;
        tick();
        chk("mr_first_grant", 32'(ack), 32'h01);
        req = '0;

        // Round robin with all requesters active
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            exp_ack   = ((k - 1) % 6 == 0) ? N'(1) << (((k - 1) / 6) % 5) : '0;
            exp_valid = (k % 6 == 0) ? N'(1) << ((k / 6 - 1) % 5) : '0;
            chk("rr_ack", 32'(ack), 32'(exp_ack));
            chk("rr_valid", 32'(valid), 32'(exp_valid));
        end
        req = '0;

        // Byte write from requester 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 5'b00010; req_we = 5'b00010; req_size = 5'b11101;
        req_din[1*16 +: 16] = 16'h00A5;
        tick();
        chk("wr_ack", 32'(ack), 32'h02);
        chk("wr_we", 32'(we_n), 32'd0);
        chk("wr_oe", 32'(oe_n), 32'd1);
        chk("wr_din", 32'(ram_din), 32'h00A5);
        chk("wr_size", 32'(ram_din_size), 32'd0);
        tick();
        req = '0; req_we = '0;
        chk("wr_we_end", 32'(we_n), 32'd1);
        for (int k = 3; k <= 8; k++) begin
            tick();
            chk("wr_no_valid", 32'(valid), 32'd0);
        end

        // Refresh and request colliding in the same idle cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 64; k++) tick();
        chk("col_rfsh_pre", 32'(rfsh_n), 32'd1);
        req = 5'b00001;
        tick();
        chk("col_rfsh", 32'(rfsh_n), 32'd0);
        chk("col_no_ack", 32'(ack), 32'd0);
        tick();
        chk("col_rfsh_end", 32'(rfsh_n), 32'd1);
        tick(); tick(); tick(); tick();
        chk("col_ack_wait", 32'(ack), 32'd0);
        tick();
        chk("col_ack", 32'(ack), 32'h01);
        chk("col_oe", 32'(oe_n), 32'd0);
        req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares one external RAM port (OE_n/WE_n/RFSH_n style, fixed access latency) among COUNT cartridge-side requesters, such as megarom, FM BIOS, Nextor, RAM cartridge and bootloader.
- Arbitrates round-robin and schedules periodic refresh that preempts queued requests but never aborts an access in progress.
- Sits between the cartridge blocks and the RAM controller at the top level.

Parameters:
COUNT, 5, number of requesters (2..8)
ADDR_W, 22, RAM address width
ACCESS_CYCLES, 4, cycles the RAM needs after a command before data is valid or the port is free (>=1)
REFRESH_INTERVAL, 256, cycles between refresh requests (> COUNT*(ACCESS_CYCLES+2))

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous reset, active-high
REQ  in  COUNT  per-requester access request (level, held until ACK)
REQ_WE  in  COUNT  per-requester 1=write, 0=read
REQ_ADDR  in  COUNT*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
REQ_DIN  in  COUNT*16  packed write data
REQ_SIZE  in  COUNT  write size, 0=byte (DIN[7:0]), 1=word
ACK  out  COUNT  one-cycle one-hot grant pulse
VALID  out  COUNT  one-cycle one-hot read-data-valid pulse
DOUT  out  16  read data, broadcast, qualified by VALID
RAM_ADDR  out  ADDR_W  RAM address
RAM_DIN  out  16  RAM write data
RAM_DIN_SIZE  out  1  RAM write size
RAM_OE_n  out  1  read strobe, active-low, 1 cycle
RAM_WE_n  out  1  write strobe, active-low, 1 cycle
RAM_RFSH_n  out  1  refresh strobe, active-low, 1 cycle
RAM_DOUT  in  16  RAM read data
RFSH_MISSED  out  1  sticky: refresh interval elapsed while a refresh was still pending

Behaviour:
- Reset (async, immediate): state IDLE; ACK=0, VALID=0, DOUT=0; RAM_ADDR=0, RAM_DIN=0, RAM_DIN_SIZE=0; RAM_OE_n=RAM_WE_n=RAM_RFSH_n=1; RFSH_MISSED=0; rfsh_pending=0; refresh counter=REFRESH_INTERVAL-1; last_grant=COUNT-1, so requester 0 wins first. A reset mid-access drops the access; no ACK or VALID is issued afterwards.
- All outputs are registered.
- States:
  - IDLE: if rfsh_pending -> RFSH. Else if any REQ -> CMD. Else stay.
  - CMD: one cycle, strobes asserted -> WAIT.
  - RFSH: one cycle, RAM_RFSH_n=0; clear rfsh_pending -> WAIT.
  - WAIT: counts ACCESS_CYCLES cycles -> IDLE.
- Arbitration (in IDLE, cycle t): winner is the first REQ[i] set searching from (last_grant+1) mod COUNT upward with wrap. Latch the winner's WE/ADDR/DIN/SIZE and set last_grant=winner.
- Cycle t+1 (CMD):
  - ACK[winner]=1 for exactly this cycle; the requester may drop or change REQ from t+2.
  - RAM_ADDR/DIN/DIN_SIZE are driven from the latch and held constant through CMD and WAIT.
  - RAM_OE_n=0 for a read, or RAM_WE_n=0 for a write, for this one cycle only.
- Read completion: RAM_DOUT is sampled on the last WAIT cycle (t+1+ACCESS_CYCLES). DOUT holds that value and VALID[winner]=1 at t+2+ACCESS_CYCLES, which is also an IDLE cycle where the next arbitration happens. DOUT holds its value until the next read completes.
- Writes produce no VALID.
- Back-to-back throughput: one access per ACCESS_CYCLES+2 cycles.
- Refresh counter:
  - Decrements every cycle regardless of state.
  - At 0 it reloads to REFRESH_INTERVAL-1 and sets rfsh_pending.
  - If rfsh_pending is already set at that moment, RFSH_MISSED is set (sticky until reset). Only one refresh stays pending.
- Refresh priority: when rfsh_pending and REQ arrive in the same IDLE cycle, refresh wins. The request is held, gets no ACK, and is arbitrated in the IDLE cycle after refresh completes. last_grant is unchanged by refresh.
- Simultaneous requests from all COUNT requesters are served strictly in rotation. No requester waits more than COUNT-1 accesses plus one refresh.
- REQ dropped before ACK is not an error; the request is simply not served. REQ sampled only in IDLE.
- Never more than one of RAM_OE_n/RAM_WE_n/RAM_RFSH_n low in any cycle.

Test Plan:
- Reset, single read: REQ[2]=1, ADDR=0x001234, ACCESS_CYCLES=4. Expect ACK[2] 1 cycle later with RAM_OE_n=0 and RAM_ADDR=0x001234 for that cycle. RAM_DOUT=0xBEEF on the 4th WAIT cycle gives DOUT=0xBEEF and VALID[2] at REQ+6.
- Round-robin: REQ=5'b11111 held, re-asserted after each ACK. ACK order is 0,1,2,3,4,0. Accesses are spaced 6 cycles apart.
- Write byte: REQ[1] with WE=1, SIZE=0, DIN=0x00A5. Expect RAM_WE_n=0 one cycle, RAM_DIN_SIZE=0, RAM_DIN=0x00A5, and no VALID.
- Refresh collision: with rfsh_pending, REQ[0] is asserted in the same cycle. Expect RAM_RFSH_n=0 first, then ACK[0] issued 1+ACCESS_CYCLES+1 cycles later.
- Refresh starvation: REFRESH_INTERVAL=8, ACCESS_CYCLES=4, continuous requests. Expect a refresh every interval, and RFSH_MISSED stays 0 while the interval is legal. Force RESET-hold stimulus to show RFSH_MISSED=1 only when two interval expiries occur with one pending.
- Reset mid-WAIT of a read: pulse RESET. Expect all strobes high immediately, no VALID afterwards, and the next grant goes to requester 0.
